// File: rtl/fetch_sequencer_if.sv
// Fetch-side bundle: byte-wide memory read port, branch redirect and the decode handshake.
// master = fetch_sequencer, slave = memory/front-end/decode side.
interface fetch_sequencer_if #(
    parameter int ADDR_W = 64
);
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_data;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic              inst_valid;
    logic [31:0]       inst;
    logic [ADDR_W-1:0] inst_pc;
    logic              inst_ready;
    logic              fetch_fault;

    modport master (
        output mem_req, mem_addr, inst_valid, inst, inst_pc, fetch_fault,
        input  mem_data, redirect, redirect_pc, inst_ready
    );

    modport slave (
        input  mem_req, mem_addr, inst_valid, inst, inst_pc, fetch_fault,
        output mem_data, redirect, redirect_pc, inst_ready
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction fetch: owns the PC, reads each word as 4 pipelined big-endian byte reads into an in-order queue.
// Latency: 5 cycles from byte-0 issue to inst_valid; steady state 1 word per 4 cycles.
// Backpressure: a new word starts only while queued + in-flight words < QUEUE_DEPTH; redirect flushes.
module fetch_sequencer #(
    parameter int                ADDR_W      = 64,
    parameter int                MEM_BYTES   = 64,
    parameter int                QUEUE_DEPTH = 2,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    fetch_sequencer_if.master bus
);
    localparam int                PTR_W     = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int                CNT_W     = $clog2(QUEUE_DEPTH + 1);
    localparam logic [PTR_W-1:0]  LAST_SLOT = PTR_W'(QUEUE_DEPTH - 1);
    localparam logic [ADDR_W-1:0] PC_LIMIT  = ADDR_W'(MEM_BYTES - 3);

    localparam logic [0:0] S_FETCH = 1'b0;
    localparam logic [0:0] S_FAULT = 1'b1;

    logic [0:0]        state;
    logic [ADDR_W-1:0] pc;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [1:0]        byte_idx;
    logic              rd_vld;
    logic [1:0]        rd_idx;
    logic [ADDR_W-1:0] rd_pc;
    logic [23:0]       asm_bytes;

    logic [31:0]       q_word [QUEUE_DEPTH];
    logic [ADDR_W-1:0] q_pc   [QUEUE_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  q_cnt;
    logic [31:0]       last_word;
    logic [ADDR_W-1:0] last_pc;

    logic              push;
    logic              pop;
    logic              mid_word;
    logic              last_in_flight;
    logic              can_start;
    logic [CNT_W:0]    demand;
    logic              head_vld;

    function automatic logic pc_legal(input logic [ADDR_W-1:0] a);
        return (a[1:0] == 2'b00) && (a < PC_LIMIT);
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_SLOT) ? '0 : p + PTR_W'(1);
    endfunction

    // The word whose last byte issues this cycle still counts as in flight at this edge.
    always_comb begin
        head_vld       = (q_cnt != '0);
        push           = rd_vld && (rd_idx == 2'd3) && !bus.redirect;
        pop            = head_vld && bus.inst_ready && !bus.redirect;
        mid_word       = mem_req && (byte_idx != 2'd3);
        last_in_flight = mem_req && (byte_idx == 2'd3);
        demand         = {1'b0, q_cnt} + (CNT_W+1)'(push) - (CNT_W+1)'(pop)
                         + (CNT_W+1)'(last_in_flight);
        can_start      = demand < (CNT_W+1)'(QUEUE_DEPTH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_FETCH;
            pc        <= RESET_PC;
            mem_req   <= 1'b0;
            mem_addr  <= '0;
            byte_idx  <= '0;
            rd_vld    <= 1'b0;
            rd_idx    <= '0;
            rd_pc     <= '0;
            asm_bytes <= '0;
        end else if (bus.redirect) begin
            rd_vld   <= 1'b0;
            byte_idx <= '0;
            if (pc_legal(bus.redirect_pc)) begin
                state    <= S_FETCH;
                mem_req  <= 1'b1;
                mem_addr <= bus.redirect_pc;
                pc       <= bus.redirect_pc + ADDR_W'(4);
            end else begin
                state   <= S_FAULT;
                mem_req <= 1'b0;
                pc      <= bus.redirect_pc;
            end
        end else begin
            rd_vld <= mem_req;
            rd_idx <= byte_idx;
            rd_pc  <= {mem_addr[ADDR_W-1:2], 2'b00};
            if (rd_vld)
                asm_bytes <= {asm_bytes[15:0], bus.mem_data};
            // pc already points at the word after the one being issued
            if (mid_word) begin
                mem_req  <= 1'b1;
                mem_addr <= mem_addr + ADDR_W'(1);
                byte_idx <= byte_idx + 2'd1;
            end else if ((state == S_FETCH) && !pc_legal(pc)) begin
                state   <= S_FAULT;
                mem_req <= 1'b0;
            end else if ((state == S_FETCH) && can_start) begin
                mem_req  <= 1'b1;
                mem_addr <= pc;
                byte_idx <= '0;
                pc       <= pc + ADDR_W'(4);
            end else begin
                mem_req <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            q_cnt     <= '0;
            last_word <= '0;
            last_pc   <= '0;
        end else if (bus.redirect) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            q_cnt  <= '0;
        end else begin
            if (push)
                wr_ptr <= ptr_inc(wr_ptr);
            if (pop) begin
                rd_ptr    <= ptr_inc(rd_ptr);
                last_word <= q_word[rd_ptr];
                last_pc   <= q_pc[rd_ptr];
            end
            q_cnt <= q_cnt + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_word[wr_ptr] <= {asm_bytes, bus.mem_data};
            q_pc[wr_ptr]   <= rd_pc;
        end
    end

    assign bus.mem_req     = mem_req;
    assign bus.mem_addr    = mem_addr;
    assign bus.inst_valid  = head_vld;
    assign bus.inst        = head_vld ? q_word[rd_ptr] : last_word;
    assign bus.inst_pc     = head_vld ? q_pc[rd_ptr] : last_pc;
    assign bus.fetch_fault = (state == S_FAULT);
endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed latency/stall/redirect/fault scenarios plus random traffic against an instruction-stream model.
module tb_fetch_sequencer;
    localparam int ADDR_W      = 64;
    localparam int MEM_BYTES   = 64;
    localparam int QUEUE_DEPTH = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fetch_sequencer_if #(.ADDR_W(ADDR_W)) bus();

    fetch_sequencer #(
        .ADDR_W(ADDR_W), .MEM_BYTES(MEM_BYTES), .QUEUE_DEPTH(QUEUE_DEPTH), .RESET_PC('0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    logic [7:0]        mem [MEM_BYTES];
    int                checks   = 0;
    int                failures = 0;
    int                cyc      = 0;
    int                req_count;
    int                pops;
    logic              nx_ready = 1'b0;
    logic              nx_redir = 1'b0;
    logic [ADDR_W-1:0] nx_rpc   = '0;
    logic              prev_redir = 1'b0;
    logic [ADDR_W-1:0] prev_rpc   = '0;
    logic [ADDR_W-1:0] exp_pc     = '0;
    logic              popped;
    logic [ADDR_W-1:0] popped_pc;
    logic [31:0]       popped_inst;
    logic              pend_req  = 1'b0;
    logic [ADDR_W-1:0] pend_addr = '0;
    logic              seen;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    // A word fetch is legal when aligned and its last byte lies inside memory.
    function automatic bit legal(input logic [ADDR_W-1:0] a);
        logic [ADDR_W:0] last_byte;
        last_byte = {1'b0, a} + (ADDR_W+1)'(3);
        return (a % 4 == 0) && (last_byte < (ADDR_W+1)'(MEM_BYTES));
    endfunction

    function automatic logic [31:0] be_word(input logic [ADDR_W-1:0] a);
        int b;
        if (!legal(a)) return 32'h0;
        b = int'(a);
        return {mem[b], mem[b+1], mem[b+2], mem[b+3]};
    endfunction

    // Memory answers a request seen in cycle n with data valid during cycle n+1.
    always @(negedge clk) begin
        if (pend_req && (pend_addr < ADDR_W'(MEM_BYTES)))
            bus.mem_data = mem[int'(pend_addr)];
        else
            bus.mem_data = 8'($urandom);
        pend_req  = bus.mem_req;
        pend_addr = bus.mem_addr;
    end

    task automatic step();
        @(negedge clk);
        bus.inst_ready  = nx_ready;
        bus.redirect    = nx_redir;
        bus.redirect_pc = nx_rpc;
        nx_redir = 1'b0;
        cyc++;
        popped = 1'b0;
        if (prev_redir) begin
            check("redir_valid", 64'(bus.inst_valid), 64'd0);
            if (legal(prev_rpc)) begin
                check("redir_req", 64'(bus.mem_req), 64'd1);
                check("redir_addr", bus.mem_addr, prev_rpc);
                check("redir_nofault", 64'(bus.fetch_fault), 64'd0);
            end else begin
                check("redir_fault", 64'(bus.fetch_fault), 64'd1);
                check("redir_noreq", 64'(bus.mem_req), 64'd0);
            end
        end
        if (bus.mem_req) begin
            req_count++;
            check("req_in_range", 64'(legal({bus.mem_addr[ADDR_W-1:2], 2'b00})), 64'd1);
        end
        if (bus.inst_valid && bus.inst_ready && !bus.redirect) begin
            check("pop_pc", bus.inst_pc, exp_pc);
            check("pop_inst", 64'(bus.inst), 64'(be_word(exp_pc)));
            popped      = 1'b1;
            popped_pc   = bus.inst_pc;
            popped_inst = bus.inst;
            pops++;
            exp_pc += 4;
        end
        if (bus.redirect)
            exp_pc = bus.redirect_pc;
        prev_redir = bus.redirect;
        prev_rpc   = bus.redirect_pc;
    endtask

    task automatic do_reset();
        rst_n           = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        bus.inst_ready  = nx_ready;
        nx_redir        = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_req", 64'(bus.mem_req), 64'd0);
        check("rst_addr", bus.mem_addr, 64'd0);
        check("rst_valid", 64'(bus.inst_valid), 64'd0);
        check("rst_inst", 64'(bus.inst), 64'd0);
        check("rst_pc", bus.inst_pc, 64'd0);
        check("rst_fault", 64'(bus.fetch_fault), 64'd0);
        rst_n      = 1'b1;
        cyc        = -1;
        exp_pc     = '0;
        prev_redir = 1'b0;
        req_count  = 0;
        pops       = 0;
    endtask

    task automatic check_boot();
        nx_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            step();
            if (c < 4) begin
                check("boot_req", 64'(bus.mem_req), 64'd1);
                check("boot_addr", bus.mem_addr, 64'(c));
            end
            if (c == 4) check("boot_early_valid", 64'(bus.inst_valid), 64'd0);
            if (c == 5) begin
                check("boot_valid0", 64'(bus.inst_valid), 64'd1);
                check("boot_inst0", 64'(bus.inst), 64'hF84083E1);
                check("boot_pc0", bus.inst_pc, 64'd0);
            end
            if (c == 9) begin
                check("boot_valid1", 64'(bus.inst_valid), 64'd1);
                check("boot_inst1", 64'(bus.inst), 64'hF84103E2);
                check("boot_pc1", bus.inst_pc, 64'd4);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < MEM_BYTES; i++) mem[i] = 8'($urandom);
        mem[0]  = 8'hF8; mem[1]  = 8'h40; mem[2]  = 8'h83; mem[3]  = 8'hE1;
        mem[4]  = 8'hF8; mem[5]  = 8'h41; mem[6]  = 8'h03; mem[7]  = 8'hE2;
        mem[48] = 8'h8B; mem[49] = 8'h03; mem[50] = 8'h00; mem[51] = 8'h22;
        mem[60] = 8'h8A; mem[61] = 8'h0B; mem[62] = 8'h01; mem[63] = 8'h4C;
        bus.mem_data = 8'h00;

        // Boot latency and steady-state throughput
        nx_ready = 1'b1;
        do_reset();
        check_boot();

        // Decode stalled from reset: queue fills, fetch stops, drains in order
        nx_ready = 1'b0;
        do_reset();
        for (int c = 0; c < 30; c++) step();
        check("stall_req_count", 64'(req_count), 64'd8);
        check("stall_req_idle", 64'(bus.mem_req), 64'd0);
        check("stall_full", 64'(bus.inst_valid), 64'd1);
        nx_ready = 1'b1;
        step();
        check("drain0_pop", 64'(popped), 64'd1);
        check("drain0_inst", 64'(popped_inst), 64'hF84083E1);
        step();
        check("drain_reissue", 64'(bus.mem_req), 64'd1);
        check("drain1_pop", 64'(popped), 64'd1);
        check("drain1_inst", 64'(popped_inst), 64'hF84103E2);

        // Redirect during byte-2 issue with one word queued
        nx_ready = 1'b0;
        do_reset();
        for (int c = 0; c < 6; c++) step();
        nx_redir = 1'b1;
        nx_rpc   = 64'h30;
        step();
        check("t3_byte2_addr", bus.mem_addr, 64'd6);
        check("t3_queued", 64'(bus.inst_valid), 64'd1);
        for (int c = 7; c <= 12; c++) begin
            step();
            if (c < 12) check("t3_no_valid", 64'(bus.inst_valid), 64'd0);
        end
        check("t3_valid", 64'(bus.inst_valid), 64'd1);
        check("t3_inst", 64'(bus.inst), 64'h8B030022);
        check("t3_pc", bus.inst_pc, 64'h30);
        nx_ready = 1'b1;
        step();
        check("t3_pop", 64'(popped), 64'd1);

        // Misaligned redirect faults, legal redirect recovers
        nx_redir = 1'b1;
        nx_rpc   = 64'h32;
        step();
        step();
        for (int c = 0; c < 3; c++) begin
            step();
            check("t4_fault_hold", 64'(bus.fetch_fault), 64'd1);
            check("t4_req_hold", 64'(bus.mem_req), 64'd0);
        end
        nx_redir = 1'b1;
        nx_rpc   = 64'h3C;
        step();
        seen = 1'b0;
        for (int c = 0; c < 12 && !seen; c++) begin
            step();
            if (popped && popped_pc == 64'h3C) begin
                seen = 1'b1;
                check("t4_inst", 64'(popped_inst), 64'h8A0B014C);
            end
        end
        check("t4_delivered", 64'(seen), 64'd1);

        // Sequential fetch runs off the end of memory and faults
        nx_redir = 1'b1;
        nx_rpc   = 64'h30;
        step();
        pops = 0;
        for (int c = 0; c < 40; c++) step();
        check("t5_pops", 64'(pops), 64'd4);
        check("t5_last_pc", popped_pc, 64'h3C);
        check("t5_fault", 64'(bus.fetch_fault), 64'd1);
        check("t5_req_idle", 64'(bus.mem_req), 64'd0);

        // Asynchronous reset mid-word, then a clean reboot
        nx_ready = 1'b1;
        do_reset();
        step();
        step();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_req", 64'(bus.mem_req), 64'd0);
        check("arst_addr", bus.mem_addr, 64'd0);
        check("arst_valid", 64'(bus.inst_valid), 64'd0);
        check("arst_inst", 64'(bus.inst), 64'd0);
        check("arst_pc", bus.inst_pc, 64'd0);
        check("arst_fault", 64'(bus.fetch_fault), 64'd0);
        do_reset();
        check_boot();

        // Random decode stalls and redirects against the instruction-stream model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            nx_ready = ($urandom_range(3) != 0);
            if ($urandom_range(24) == 0) begin
                nx_redir = 1'b1;
                case ($urandom_range(4))
                    0, 1:    nx_rpc = 64'($urandom_range(15)) * 64'd4;
                    2:       nx_rpc = 64'($urandom_range(15)) * 64'd4 + 64'($urandom_range(3, 1));
                    3:       nx_rpc = 64'h40 + 64'($urandom_range(15)) * 64'd4;
                    default: nx_rpc = 64'hFFFF_FFFF_FFFF_FFFC;
                endcase
            end
            step();
        end
        check("rand_progress", 64'(pops > 50), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
